// File: rtl/graph_line_plotter_if.sv
// graph_line_plotter_if: command handshake and framebuffer write port of the line plotter
interface graph_line_plotter_if #(parameter int COORD_W = 10);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [COORD_W-1:0]     cmd_x0;
  logic [COORD_W-1:0]     cmd_y0;
  logic [COORD_W-1:0]     cmd_x1;
  logic [COORD_W-1:0]     cmd_y1;
  logic [3:0]             cmd_color;
  logic [3:0]             color;
  logic [2*COORD_W-1:0]   address;
  logic                   writeEnable;
  logic                   busy;
  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    input  cmd_ready, color, address, writeEnable, busy
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
    output cmd_ready, color, address, writeEnable, busy
  );
endinterface

// File: rtl/graph_line_plotter.sv
// graph_line_plotter: plot/line/clear engine emitting one framebuffer write per cycle
module graph_line_plotter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COORD_W  = 10
) (
  input logic           clock,
  input logic           reset,
  graph_line_plotter_if.slave bus
);
  localparam int SW = COORD_W + 2;
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W:0]   HA     = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0]   VA     = (COORD_W+1)'(V_ACTIVE);
  typedef enum logic [2:0] {IDLE, PLOT, LINE_SETUP, LINE, CLEAR} state_t;
  state_t state_q;
  logic [COORD_W-1:0] x_q, y_q, ex_q, ey_q, x_d, y_d, adx, ady;
  logic signed [SW-1:0] dx_q, dy_q, err_q, err_d;
  logic signed [SW:0] e2, dx_w, dy_w;
  logic sx_q, sy_q, step_x, step_y, last;
  logic [3:0] color_q;
  logic [2*COORD_W-1:0] addr_q;
  logic we_q;
  function automatic logic vis(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return {1'b0, x} < HA && {1'b0, y} < VA;
  endfunction
  always_comb begin
    e2 = {err_q, 1'b0};
    dx_w = dx_q;
    dy_w = dy_q;
    step_x = e2 >= dy_w;
    step_y = e2 <= dx_w;
    err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    adx = ex_q >= x_q ? ex_q - x_q : x_q - ex_q;
    ady = ey_q >= y_q ? ey_q - y_q : y_q - ey_q;
    // CLEAR walks the raster; LINE takes the Bresenham step
    x_d = state_q == CLEAR ? (x_q == H_LAST ? '0 : x_q + ONE)
        : step_x ? (sx_q ? x_q - ONE : x_q + ONE) : x_q;
    y_d = state_q == CLEAR ? (x_q == H_LAST ? y_q + ONE : y_q)
        : step_y ? (sy_q ? y_q - ONE : y_q + ONE) : y_q;
    last = state_q == CLEAR ? x_q == H_LAST && y_q == V_LAST : x_q == ex_q && y_q == ey_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      color_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          we_q <= 1'b0;
          if (bus.cmd_valid) begin
            state_q <= bus.cmd_op == 2'd0 ? PLOT : bus.cmd_op == 2'd1 ? LINE_SETUP
                     : bus.cmd_op == 2'd2 ? CLEAR : IDLE;
            color_q <= bus.cmd_color;
            x_q <= bus.cmd_op == 2'd2 ? '0 : bus.cmd_x0;
            y_q <= bus.cmd_op == 2'd2 ? '0 : bus.cmd_y0;
            ex_q <= bus.cmd_x1;
            ey_q <= bus.cmd_y1;
            addr_q <= bus.cmd_op == 2'd2 ? '0 : {bus.cmd_y0, bus.cmd_x0};
            we_q <= bus.cmd_op == 2'd0 ? vis(bus.cmd_x0, bus.cmd_y0) : bus.cmd_op == 2'd2;
          end
        end
        PLOT: begin
          state_q <= IDLE;
          we_q <= 1'b0;
        end
        LINE_SETUP: begin
          state_q <= LINE;
          dx_q <= SW'(adx);
          dy_q <= -SW'(ady);
          err_q <= SW'(adx) - SW'(ady);
          sx_q <= ex_q < x_q;
          sy_q <= ey_q < y_q;
          addr_q <= {y_q, x_q};
          we_q <= vis(x_q, y_q);
        end
        LINE, CLEAR: begin
          state_q <= last ? IDLE : state_q;
          x_q <= x_d;
          y_q <= y_d;
          err_q <= err_d;
          addr_q <= {y_d, x_d};
          we_q <= !last && vis(x_d, y_d);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready = state_q == IDLE && !reset;
  assign bus.busy = !bus.cmd_ready;
  assign bus.color = color_q;
  assign bus.address = addr_q;
  assign bus.writeEnable = we_q;
endmodule

// File: tb/tb_graph_line_plotter.sv
// tb_graph_line_plotter: scoreboard bench over a reduced 64x48 screen so a full clear fits the run
module tb_graph_line_plotter;
  localparam int H = 64;
  localparam int V = 48;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int wcount = 0;
  logic [23:0] exp_q[$];
  graph_line_plotter_if #(.COORD_W(10)) bus();
  graph_line_plotter #(.H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(10)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [1:0] op;
    int x0, y0, x1, y1;
    logic [3:0] c;
    int nw;
    int nb;
  } vec_t;
  vec_t v[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (bus.writeEnable === 1'b1) begin
      wcount++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write actual=%0h required=none", {bus.address, bus.color});
      end else check("write", 32'({bus.address, bus.color}), 32'(exp_q.pop_front()));
    end
  end
  function automatic void push_px(input int x, input int y, input logic [3:0] c);
    if (x < H && y < V) exp_q.push_back({10'(y), 10'(x), c});
  endfunction
  function automatic void push_line(input int x0, input int y0, input int x1, input int y1, input logic [3:0] c);
    int dx = x1 > x0 ? x1 - x0 : x0 - x1;
    int dy = y1 > y0 ? y0 - y1 : y1 - y0;
    int sx = x0 < x1 ? 1 : -1;
    int sy = y0 < y1 ? 1 : -1;
    int err = dx + dy;
    int x = x0;
    int y = y0;
    int e2;
    for (int k = 0; k < 4096; k++) begin
      push_px(x, y, c);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction
  function automatic void push_cmd(input vec_t t);
    if (t.op == 2'd0) push_px(t.x0, t.y0, t.c);
    else if (t.op == 2'd1) push_line(t.x0, t.y0, t.x1, t.y1, t.c);
    else if (t.op == 2'd2) for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) push_px(x, y, t.c);
  endfunction
  task automatic issue(input logic [1:0] op, input int x0, input int y0, input int x1, input int y1,
                       input logic [3:0] c);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 5000) begin @(posedge clock); #1; n++; end
    if (bus.cmd_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=busy required=ready");
    end
    wcount = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_x0 = 10'(x0);
    bus.cmd_y0 = 10'(y0);
    bus.cmd_x1 = 10'(x1);
    bus.cmd_y1 = 10'(y1);
    bus.cmd_color = c;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom);
    bus.cmd_x0 = 10'($urandom);
    bus.cmd_y0 = 10'($urandom);
    bus.cmd_x1 = 10'($urandom);
    bus.cmd_y1 = 10'($urandom);
    bus.cmd_color = 4'($urandom);
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 5000) begin @(posedge clock); #1; n++; end
  endtask
  task automatic reset_abort();
    reset = 1'b1;
    @(posedge clock); #1;
    exp_q.delete();
    check("abort_we", 32'(bus.writeEnable), 32'(0));
    check("abort_addr", 32'(bus.address), 32'(0));
    check("abort_color", 32'(bus.color), 32'(0));
    check("abort_ready", 32'(bus.cmd_ready), 32'(0));
    reset = 1'b0;
    @(posedge clock); #1;
    check("abort_ready_after", 32'(bus.cmd_ready), 32'(1));
  endtask
  initial begin
    int n;
    v[0]  = '{2'd0, 5, 7, 0, 0, 4'd9, 1, 1};
    v[1]  = '{2'd1, 10, 20, 10, 5, 4'd3, 16, 17};
    v[2]  = '{2'd1, 3, 3, 3, 3, 4'd5, 1, 2};
    v[3]  = '{2'd1, 630, 0, 700, 0, 4'd1, 0, 72};
    v[4]  = '{2'd1, 58, 2, 70, 2, 4'd2, 6, 14};
    v[5]  = '{2'd1, 20, 10, 2, 30, 4'd7, 21, 22};
    v[6]  = '{2'd0, 64, 0, 0, 0, 4'd4, 0, 1};
    v[7]  = '{2'd0, 63, 47, 0, 0, 4'd6, 1, 1};
    v[8]  = '{2'd1, 0, 45, 0, 50, 4'd8, 3, 7};
    v[9]  = '{2'd3, 1, 1, 2, 2, 4'd15, 0, 0};
    v[10] = '{2'd2, 0, 0, 0, 0, 4'd0, 3072, 3072};
    v[11] = '{2'd1, 40, 5, 45, 40, 4'd11, 36, 37};
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_x0 = '0;
    bus.cmd_y0 = '0;
    bus.cmd_x1 = '0;
    bus.cmd_y1 = '0;
    bus.cmd_color = '0;
    #1;
    check("ready_in_reset", 32'(bus.cmd_ready), 32'(0));
    repeat (2) begin @(posedge clock); #1; end
    check("reset_we", 32'(bus.writeEnable), 32'(0));
    check("reset_addr", 32'(bus.address), 32'(0));
    check("reset_color", 32'(bus.color), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(1));
    reset = 1'b0;
    @(posedge clock); #1;
    check("ready_after_reset", 32'(bus.cmd_ready), 32'(1));
    push_px(5, 7, 4'd9);
    issue(2'd0, 5, 7, 0, 0, 4'd9);
    check("plot_we", 32'(bus.writeEnable), 32'(1));
    check("plot_addr", 32'(bus.address), 32'({10'd7, 10'd5}));
    check("plot_color", 32'(bus.color), 32'(9));
    @(posedge clock); #1;
    check("plot_ready", 32'(bus.cmd_ready), 32'(1));
    check("plot_we_off", 32'(bus.writeEnable), 32'(0));
    exp_q.push_back({10'd0, 10'd0, 4'd10});
    exp_q.push_back({10'd1, 10'd1, 4'd10});
    exp_q.push_back({10'd1, 10'd2, 4'd10});
    exp_q.push_back({10'd2, 10'd3, 4'd10});
    exp_q.push_back({10'd2, 10'd4, 4'd10});
    issue(2'd1, 0, 0, 4, 2, 4'd10);
    check("line_setup_we", 32'(bus.writeEnable), 32'(0));
    check("line_setup_busy", 32'(bus.busy), 32'(1));
    @(posedge clock); #1;
    check("line_first_we", 32'(bus.writeEnable), 32'(1));
    check("line_first_addr", 32'(bus.address), 32'(0));
    wait_idle(n);
    check("line_writes", 32'(wcount), 32'(5));
    check("line_drained", 32'(exp_q.size()), 32'(0));
    for (int i = 0; i < 12; i++) begin
      push_cmd(v[i]);
      issue(v[i].op, v[i].x0, v[i].y0, v[i].x1, v[i].y1, v[i].c);
      wait_idle(n);
      check($sformatf("busy_cycles[%0d]", i), 32'(n), 32'(v[i].nb));
      check($sformatf("writes[%0d]", i), 32'(wcount), 32'(v[i].nw));
      check($sformatf("drained[%0d]", i), 32'(exp_q.size()), 32'(0));
    end
    push_cmd(v[10]);
    issue(2'd2, 0, 0, 0, 0, 4'd12);
    foreach (exp_q[k]) exp_q[k][3:0] = 4'd12;
    repeat (100) begin @(posedge clock); #1; end
    reset_abort();
    push_line(0, 0, 60, 40, 4'd14);
    issue(2'd1, 0, 0, 60, 40, 4'd14);
    repeat (10) begin @(posedge clock); #1; end
    reset_abort();
    push_px(9, 9, 4'd13);
    issue(2'd0, 9, 9, 0, 0, 4'd13);
    wait_idle(n);
    check("post_reset_plot_cycles", 32'(n), 32'(1));
    check("post_reset_plot_writes", 32'(wcount), 32'(1));
    check("post_reset_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
